matrix_result_streamer: RTL and testbench

//  Downstream stage of the 2x2 matrix multiplier. Captures the four 8-bit result

---
 rtl/matrix_result_streamer_if.sv | 21 ++
 rtl/matrix_result_streamer.sv | 81 ++++++++
 tb/tb_matrix_result_streamer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/matrix_result_streamer_if.sv
// matrix_result_streamer_if: result capture and beat stream bundle between multiplier, streamer and consumer.
interface matrix_result_streamer_if #(parameter int DATA_W = 8);
    logic              done_in;
    logic [DATA_W-1:0] c00, c01, c10, c11;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_idx;
    logic              out_last;
    logic              busy;
    logic              overflow;
    logic [7:0]        frame_cnt;
    modport master (
        output done_in, c00, c01, c10, c11, out_ready,
        input  out_data, out_valid, out_idx, out_last, busy, overflow, frame_cnt
    );
    modport slave (
        input  done_in, c00, c01, c10, c11, out_ready,
        output out_data, out_valid, out_idx, out_last, busy, overflow, frame_cnt
    );
endinterface

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: captures a 2x2 result on done_in and streams it one element per
// valid/ready beat, with one pending frame of buffering, a frame counter and sticky overflow.
module matrix_result_streamer #(
    parameter int DATA_W    = 8,
    parameter bit COL_MAJOR = 1'b0
) (
    input logic clk,
    input logic rst,
    matrix_result_streamer_if.slave bus
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t            state, nstate;
    logic [DATA_W-1:0] cin [4];
    logic [DATA_W-1:0] act [4];
    logic [DATA_W-1:0] pend [4];
    logic              pend_full, ovf;
    logic [1:0]        beat, idx;
    logic [7:0]        cnt;
    logic              hs, last_hs, ld_in, ld_pend, cap_pend, pend_clr, set_ovf;

    assign cin = '{bus.c00, bus.c01, bus.c10, bus.c11};
    assign hs      = (state == SEND) & bus.out_ready;
    assign last_hs = hs & (beat == 2'd3);

    always_comb begin
        nstate   = state;
        ld_in    = 1'b0;
        ld_pend  = 1'b0;
        cap_pend = 1'b0;
        pend_clr = 1'b0;
        set_ovf  = 1'b0;
        if (state == IDLE) begin
            ld_in  = bus.done_in;
            nstate = bus.done_in ? SEND : IDLE;
        end else if (last_hs) begin
            // active frame retires: pending (if any) takes its place, freeing room for a new capture
            ld_pend  = pend_full;
            cap_pend = pend_full & bus.done_in;
            pend_clr = pend_full & ~bus.done_in;
            ld_in    = ~pend_full & bus.done_in;
            nstate   = (pend_full | bus.done_in) ? SEND : IDLE;
        end else begin
            cap_pend = bus.done_in & ~pend_full;
            set_ovf  = bus.done_in & pend_full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act       <= '{default: '0};
            pend      <= '{default: '0};
            pend_full <= 1'b0;
            ovf       <= 1'b0;
            beat      <= 2'd0;
            cnt       <= 8'd0;
        end else begin
            if (hs) beat <= beat + 2'd1;
            if (last_hs) cnt <= cnt + 8'd1;
            if (set_ovf) ovf <= 1'b1;
            if (cap_pend) pend_full <= 1'b1;
            else if (pend_clr) pend_full <= 1'b0;
            if (ld_in) act <= cin;
            else if (ld_pend) act <= pend;
            if (cap_pend) pend <= cin;
        end
    end

    assign idx           = COL_MAJOR ? {beat[0], beat[1]} : beat;
    assign bus.out_valid = (state == SEND);
    assign bus.out_idx   = idx;
    assign bus.out_data  = act[idx];
    assign bus.out_last  = (state == SEND) & (beat == 2'd3);
    assign bus.busy      = (state == SEND) | pend_full;
    assign bus.overflow  = ovf;
    assign bus.frame_cnt = cnt;
endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb_matrix_result_streamer: drives row- and column-major streamers with identical stimulus
// and compares both against a frame-queue reference model.
module tb_matrix_result_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_result_streamer_if #(.DATA_W(8)) ifr ();
    matrix_result_streamer_if #(.DATA_W(8)) ifc ();

    matrix_result_streamer #(.DATA_W(8), .COL_MAJOR(1'b0)) dut_r (.clk(clk), .rst(rst), .bus(ifr.slave));
    matrix_result_streamer #(.DATA_W(8), .COL_MAJOR(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    int n_chk = 0;
    int n_err = 0;

    // model: queue of accepted frames (front is streaming), beats done of the front frame
    logic [31:0] fq [$];
    int          mbeat = 0;
    logic        movf  = 1'b0;
    int          mcnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        mbeat = 0;
        movf  = 1'b0;
        mcnt  = 0;
    endtask

    task automatic model_step(input logic d, input logic [31:0] cin, input logic rdy);
        logic leave;
        leave = (fq.size() > 0) && rdy && (mbeat == 3);
        if ((fq.size() > 0) && rdy) mbeat = (mbeat + 1) % 4;
        if (leave) begin
            void'(fq.pop_front());
            mcnt = (mcnt + 1) % 256;
        end
        if (d) begin
            if (fq.size() < 2) fq.push_back(cin);
            else movf = 1'b1;
        end
    endtask

    task automatic check_all();
        logic        v;
        logic [31:0] f;
        int          ic;
        v = (fq.size() > 0);
        chk("valid_row", {31'd0, ifr.out_valid}, {31'd0, v});
        chk("valid_col", {31'd0, ifc.out_valid}, {31'd0, v});
        chk("busy_row", {31'd0, ifr.busy}, {31'd0, v});
        chk("busy_col", {31'd0, ifc.busy}, {31'd0, v});
        chk("ovf_row", {31'd0, ifr.overflow}, {31'd0, movf});
        chk("ovf_col", {31'd0, ifc.overflow}, {31'd0, movf});
        chk("cnt_row", {24'd0, ifr.frame_cnt}, mcnt);
        chk("cnt_col", {24'd0, ifc.frame_cnt}, mcnt);
        if (v) begin
            f  = fq[0];
            ic = (mbeat == 1) ? 2 : (mbeat == 2) ? 1 : mbeat;
            chk("idx_row", {30'd0, ifr.out_idx}, mbeat);
            chk("idx_col", {30'd0, ifc.out_idx}, ic);
            chk("data_row", {24'd0, ifr.out_data}, {24'd0, f[8*mbeat +: 8]});
            chk("data_col", {24'd0, ifc.out_data}, {24'd0, f[8*ic +: 8]});
            chk("last_row", {31'd0, ifr.out_last}, {31'd0, mbeat == 3});
            chk("last_col", {31'd0, ifc.out_last}, {31'd0, mbeat == 3});
        end
    endtask

    task automatic drive(input logic d, input logic [31:0] cin, input logic rdy);
        ifr.done_in = d;  ifc.done_in = d;
        ifr.c00 = cin[7:0];   ifc.c00 = cin[7:0];
        ifr.c01 = cin[15:8];  ifc.c01 = cin[15:8];
        ifr.c10 = cin[23:16]; ifc.c10 = cin[23:16];
        ifr.c11 = cin[31:24]; ifc.c11 = cin[31:24];
        ifr.out_ready = rdy;  ifc.out_ready = rdy;
    endtask

    task automatic cycle(input logic d, input logic [31:0] cin, input logic rdy);
        check_all();
        drive(d, cin, rdy);
        @(posedge clk);
        model_step(d, cin, rdy);
        #1;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", {31'd0, ifr.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, ifr.busy}, 32'd0);
        chk("rst_ovf", {31'd0, ifr.overflow}, 32'd0);
        chk("rst_cnt", {24'd0, ifr.frame_cnt}, 32'd0);
        chk("rst_cnt_col", {24'd0, ifc.frame_cnt}, 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] FA = {8'd29, 8'd22, 8'd13, 8'd10};
    localparam logic [31:0] FB = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] FC = {8'd8, 8'd7, 8'd6, 8'd5};

    initial begin
        logic [7:0] t1 [4];
        t1 = '{8'd10, 8'd13, 8'd22, 8'd29};
        drive(1'b0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all();

        // basic row-major frame
        cycle(1'b1, FA, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_data", {24'd0, ifr.out_data}, {24'd0, t1[i]});
            cycle(1'b0, 32'd0, 1'b1);
        end
        chk("t1_cnt", {24'd0, ifr.frame_cnt}, 32'd1);
        chk("t1_idle", {31'd0, ifr.out_valid}, 32'd0);

        // consumer stalls
        cycle(1'b1, FA, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 32'd0, (i % 3) == 0);
        repeat (3) cycle(1'b0, 32'd0, 1'b1);

        // one pending frame, back-to-back streaming
        cycle(1'b1, FA, 1'b0);
        cycle(1'b1, FB, 1'b0);
        repeat (2) cycle(1'b0, 32'd0, 1'b0);
        repeat (10) cycle(1'b0, 32'd0, 1'b1);
        chk("t3_ovf", {31'd0, ifr.overflow}, 32'd0);

        // third frame while pending full is dropped
        cycle(1'b1, FA, 1'b0);
        cycle(1'b1, FB, 1'b0);
        cycle(1'b1, FC, 1'b0);
        repeat (10) cycle(1'b0, 32'd0, 1'b1);
        chk("t4_ovf", {31'd0, ifr.overflow}, 32'd1);

        // reset during beat 2, then a fresh frame
        cycle(1'b1, FB, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        chk("t6_beat2", {30'd0, ifr.out_idx}, 32'd2);
        async_reset();
        cycle(1'b1, FC, 1'b1);
        repeat (5) cycle(1'b0, 32'd0, 1'b1);

        // new frame arrives on the last handshake while another is pending
        async_reset();
        cycle(1'b1, FA, 1'b0);
        cycle(1'b1, FB, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b1, FC, 1'b1);
        chk("t5_ovf", {31'd0, ifr.overflow}, 32'd0);
        repeat (12) cycle(1'b0, 32'd0, 1'b1);

        // light load long enough to wrap frame_cnt
        for (int i = 0; i < 2000; i++)
            cycle($urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 7) != 0);
        // heavy contention
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 1);
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
